// File: rtl/vram_arbiter.sv
// Two-requester arbiter for a single-port synchronous VRAM (CPU read/write, video scanout read-only).
// Latency: address/write registered at acceptance; read data returned 2 cycles after acceptance.
// Backpressure: combinational grants, video has priority; a starvation counter forces a CPU slot.
module vram_arbiter #(
  parameter int AW           = 15,
  parameter int DW           = 12,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          CLK1_50,
  input  logic          RST_N,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_WDATA,
  output logic          CPU_GNT,
  output logic [DW-1:0] CPU_RDATA,
  output logic          CPU_RVALID,
  input  logic          VID_REQ,
  input  logic [AW-1:0] VID_ADDR,
  output logic          VID_GNT,
  output logic [DW-1:0] VID_RDATA,
  output logic          VID_RVALID,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  output logic          STARVE_HIT
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]    starve_cnt_q, starve_cnt_d;
  logic          force_cpu;
  logic          cpu_gnt, vid_gnt;

  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic          starve_hit_q, starve_hit_d;

  // stage-1 tag: access in flight toward the RAM; stage-2 tag: RAM data on MEM_RDATA
  logic          t1_vld_q, t1_vld_d;
  logic          t1_vid_q, t1_vid_d;
  logic          t1_we_q, t1_we_d;
  logic          t2_rd_q, t2_rd_d;
  logic          t2_vid_q, t2_vid_d;

  // Grant decision: video wins unless the CPU has waited STARVE_LIMIT cycles; nothing granted in reset
  always_comb begin
    force_cpu = CPU_REQ && (starve_cnt_q >= LIMIT);
    cpu_gnt   = RST_N && CPU_REQ && (!VID_REQ || force_cpu);
    vid_gnt   = RST_N && VID_REQ && !cpu_gnt;
  end

  assign CPU_GNT = cpu_gnt;
  assign VID_GNT = vid_gnt;

  // Next-state for starvation counter, RAM request registers and pipeline tags
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!CPU_REQ || cpu_gnt) begin
      starve_cnt_d = 8'd0;
    end else if (starve_cnt_q != 8'hFF) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end

    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    t1_vld_d    = 1'b0;
    t1_vid_d    = 1'b0;
    t1_we_d     = 1'b0;
    if (cpu_gnt) begin
      mem_addr_d  = CPU_ADDR;
      mem_wdata_d = CPU_WDATA;
      mem_we_d    = CPU_WE;
      t1_vld_d    = 1'b1;
      t1_we_d     = CPU_WE;
    end else if (vid_gnt) begin
      mem_addr_d  = VID_ADDR;
      t1_vld_d    = 1'b1;
      t1_vid_d    = 1'b1;
    end

    // only reads produce a response strobe
    t2_rd_d      = t1_vld_q && !t1_we_q;
    t2_vid_d     = t1_vid_q;
    starve_hit_d = cpu_gnt && force_cpu && VID_REQ;
  end

  // Register stage: reset discards any in-flight reads
  always_ff @(posedge CLK1_50 or negedge RST_N) begin
    if (!RST_N) begin
      starve_cnt_q <= 8'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      t1_vld_q     <= 1'b0;
      t1_vid_q     <= 1'b0;
      t1_we_q      <= 1'b0;
      t2_rd_q      <= 1'b0;
      t2_vid_q     <= 1'b0;
      starve_hit_q <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      t1_vld_q     <= t1_vld_d;
      t1_vid_q     <= t1_vid_d;
      t1_we_q      <= t1_we_d;
      t2_rd_q      <= t2_rd_d;
      t2_vid_q     <= t2_vid_d;
      starve_hit_q <= starve_hit_d;
    end
  end

  assign MEM_ADDR   = mem_addr_q;
  assign MEM_WE     = mem_we_q;
  assign MEM_WDATA  = mem_wdata_q;
  assign STARVE_HIT = starve_hit_q;
  assign CPU_RVALID = t2_rd_q && !t2_vid_q;
  assign VID_RVALID = t2_rd_q && t2_vid_q;
  assign CPU_RDATA  = MEM_RDATA;
  assign VID_RDATA  = MEM_RDATA;

endmodule
